// File: rtl/hilo_unit_if.sv
// -----------------------------------------------------------------------------
// hilo_unit_if
//
// Purpose:
//   Bundles the pipeline-facing signals of the HI/LO register stage.
//   Clock and reset are plain ports on the unit and are not part of this bundle.
//
// Modports:
//   master : the pipeline/hazard side. Drives the control and data inputs and
//            observes HI, LO, ReadData and Busy.
//   slave  : the hilo_unit itself.
//
// Signals:
//   Start        launch the operation selected by MDCCtrl this cycle
//   MDCCtrl[2:0] 1 = mult, 2 = multu, 3 = div, 4 = divu, other = no-op
//   SrcA[31:0]   mthi/mtlo write data
//   SrcB[31:0]   divisor (only used for divide-by-zero detection)
//   MDCResult_hi combinational MDC high result
//   MDCResult_lo combinational MDC low result
//   HIWrite      mthi request
//   LOWrite      mtlo request
//   ReadSel      0 = LO, 1 = HI on ReadData
//   HI, LO       architectural registers
//   ReadData     mfhi/mflo data (combinational mux of HI/LO)
//   Busy         registered, high while a mult/div is in flight
// -----------------------------------------------------------------------------
interface hilo_unit_if;
    logic        Start;
    logic [2:0]  MDCCtrl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [31:0] MDCResult_hi;
    logic [31:0] MDCResult_lo;
    logic        HIWrite;
    logic        LOWrite;
    logic        ReadSel;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] ReadData;
    logic        Busy;

    modport master (
        output Start, MDCCtrl, SrcA, SrcB, MDCResult_hi, MDCResult_lo,
               HIWrite, LOWrite, ReadSel,
        input  HI, LO, ReadData, Busy
    );

    modport slave (
        input  Start, MDCCtrl, SrcA, SrcB, MDCResult_hi, MDCResult_lo,
               HIWrite, LOWrite, ReadSel,
        output HI, LO, ReadData, Busy
    );
endinterface

// File: rtl/hilo_unit.sv
// -----------------------------------------------------------------------------
// hilo_unit
//
// Purpose:
//   HI/LO register stage that sits directly behind the combinational
//   multiply/divide calculator (MDC). A valid Start captures the MDC result
//   immediately, because the MDC operands move on after that edge. The unit
//   then holds Busy for the architectural latency of the instruction, and
//   finally commits the captured result to HI/LO. In IDLE it also services
//   mthi/mtlo writes. ReadData provides the mfhi/mflo mux.
//
// Parameters:
//   MULT_CYCLES : busy cycles for mult/multu (1..15, 0 is treated as 1)
//   DIV_CYCLES  : busy cycles for div/divu   (1..15, 0 is treated as 1)
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   bus    : hilo_unit_if.slave (see rtl/hilo_unit_if.sv)
//
// Configuration macro:
//   HILO_DIV0_HOLD_EN : when defined, a div/divu with a zero divisor still
//                       runs its full busy period, but it leaves HI/LO
//                       unchanged at commit. When undefined, the captured MDC
//                       values are always committed.
// -----------------------------------------------------------------------------
module hilo_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    hilo_unit_if.slave   bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // A zero latency would never reach the cnt==1 commit point, so clamp it to 1.
    localparam int         MULT_EFF  = (MULT_CYCLES < 1) ? 1 : MULT_CYCLES;
    localparam int         DIV_EFF   = (DIV_CYCLES  < 1) ? 1 : DIV_CYCLES;
    localparam logic [3:0] MULT_LOAD = MULT_EFF[3:0];
    localparam logic [3:0] DIV_LOAD  = DIV_EFF[3:0];

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
`ifdef HILO_DIV0_HOLD_EN
    logic        r_pend_keep;
`endif

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_start_ok;
    logic        w_div_zero;
    logic [3:0]  w_load;

    // ---------------------------------------------------------------------
    // Opcode decode
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of an always_comb gets a default first. A path
        // that leaves it unassigned would otherwise infer a latch.
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        case (bus.MDCCtrl)
            3'd1, 3'd2: w_is_mul = 1'b1;
            3'd3, 3'd4: w_is_div = 1'b1;
            default:    ;
        endcase
        w_start_ok = bus.Start && (w_is_mul || w_is_div);
        w_div_zero = w_is_div && (bus.SrcB == 32'd0);
        w_load     = w_is_div ? DIV_LOAD : MULT_LOAD;
    end

`ifndef HILO_DIV0_HOLD_EN
    // The divisor only matters for the divide-by-zero hold feature.
    logic w_unused_div_zero;
    assign w_unused_div_zero = w_div_zero;
`endif

    // ---------------------------------------------------------------------
    // Control FSM, countdown, pending capture and architectural HI/LO
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: pend_hi/pend_lo are cleared on reset as well. An abort then
            // leaves no stale result that a later path could commit.
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_busy    <= 1'b0;
`ifdef HILO_DIV0_HOLD_EN
            r_pend_keep <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments only. All
            // right-hand sides therefore read pre-edge values, whatever the
            // statement order.
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        // The MDC is combinational and its operands change after
                        // this edge, so the result is captured now. A valid Start
                        // takes priority and any concurrent mthi/mtlo is dropped.
                        r_pend_hi <= bus.MDCResult_hi;
                        r_pend_lo <= bus.MDCResult_lo;
                        r_cnt     <= w_load;
                        r_state   <= S_BUSY;
                        r_busy    <= 1'b1;
`ifdef HILO_DIV0_HOLD_EN
                        r_pend_keep <= w_div_zero;
`endif
                    end else begin
                        if (bus.HIWrite) r_hi <= bus.SrcA;
                        if (bus.LOWrite) r_lo <= bus.SrcA;
                    end
                end

                S_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    // A cnt of 0 here is unreachable. It is folded into the
                    // commit case so the FSM can never lock up in BUSY.
                    if (r_cnt <= 4'd1) begin
`ifdef HILO_DIV0_HOLD_EN
                        if (!r_pend_keep) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
`else
                        r_hi <= r_pend_hi;
                        r_lo <= r_pend_lo;
`endif
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: ReadData only ever shows committed registers
    // ---------------------------------------------------------------------
    assign bus.HI       = r_hi;
    assign bus.LO       = r_lo;
    assign bus.Busy     = r_busy;
    assign bus.ReadData = bus.ReadSel ? r_hi : r_lo;

endmodule

// File: tb/tb_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_unit
//
// Self-checking bench for hilo_unit (MULT_CYCLES=5, DIV_CYCLES=10).
// Expected commit results are pushed to a scoreboard queue at launch. They are
// popped and compared when Busy falls. Inputs change and outputs are sampled
// on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_hilo_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic clk;
    logic reset;
    hilo_unit_if bus ();

    hilo_unit #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.Start   = 1'b0;
        bus.MDCCtrl = 3'd0;
        bus.HIWrite = 1'b0;
        bus.LOWrite = 1'b0;
    endtask

    // Called at a falling edge. Drives a launch for one cycle, then scrambles
    // the MDC outputs the way a moving operand would.
    task automatic launch(input logic [2:0] ctrl, input logic [31:0] srcb,
                          input logic [31:0] rhi, input logic [31:0] rlo,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int n, input logic also_lowrite);
        exp_t e;
        bus.Start        = 1'b1;
        bus.MDCCtrl      = ctrl;
        bus.SrcB         = srcb;
        bus.MDCResult_hi = rhi;
        bus.MDCResult_lo = rlo;
        bus.LOWrite      = also_lowrite;
        bus.SrcA         = 32'h5555_5555;
        e.hi = ehi; e.lo = elo; e.cycles = n;
        sb.push_back(e);
        @(negedge clk);
        idle_inputs();
        bus.MDCResult_hi = 32'hDEAD_BEEF;
        bus.MDCResult_lo = 32'hDEAD_BEEF;
    endtask

    // Counts busy cycles (bounded). HI/LO must hold their committed values
    // while busy. On busy cycle disturb_at, a Start and an mthi are injected.
    task automatic wait_commit(input int disturb_at);
        int   busy_cnt = 0;
        exp_t e;
        for (int i = 0; i < 40 && bus.Busy === 1'b1; i++) begin
            busy_cnt++;
            check("hold_hi", bus.HI, m_hi);
            check("hold_lo", bus.LO, m_lo);
            if (busy_cnt == disturb_at) begin
                bus.Start   = 1'b1;
                bus.MDCCtrl = 3'd1;
                bus.HIWrite = 1'b1;
                bus.SrcA    = 32'hBAD0_BAD0;
            end else begin
                idle_inputs();
            end
            @(negedge clk);
        end
        idle_inputs();
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("busy_cycles", 32'(busy_cnt), 32'(e.cycles));
            check("commit_hi", bus.HI, e.hi);
            check("commit_lo", bus.LO, e.lo);
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    task automatic mt_write(input logic hiw, input logic low, input logic [31:0] val);
        bus.HIWrite = hiw;
        bus.LOWrite = low;
        bus.SrcA    = val;
        @(negedge clk);
        idle_inputs();
        if (hiw) m_hi = val;
        if (low) m_lo = val;
        check("mt_hi", bus.HI, m_hi);
        check("mt_lo", bus.LO, m_lo);
    endtask

    initial begin
        reset            = 1'b0;
        bus.SrcA         = 32'd0;
        bus.SrcB         = 32'd0;
        bus.MDCResult_hi = 32'd0;
        bus.MDCResult_lo = 32'd0;
        bus.ReadSel      = 1'b0;
        idle_inputs();

        // 1. Reset, then mult.
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_hi", bus.HI, 32'd0);
        check("rst_lo", bus.LO, 32'd0);
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("rst_rdata", bus.ReadData, 32'd0);

        launch(3'd1, 32'd7, 32'h1234_5678, 32'h9ABC_DEF0,
               32'h1234_5678, 32'h9ABC_DEF0, MULT_N, 1'b0);
        wait_commit(0);

        // 2. divu, with a Start and an mthi injected in busy cycle 3.
        launch(3'd4, 32'd3, 32'h0000_0001, 32'h0000_0005,
               32'h0000_0001, 32'h0000_0005, DIV_N, 1'b0);
        wait_commit(3);
        check("idle_after", {31'd0, bus.Busy}, 32'd0);

        // 3. mthi and the ReadData mux.
        mt_write(1'b1, 1'b0, 32'hCAFE_F00D);
        bus.ReadSel = 1'b1;
        #1 check("rd_hi", bus.ReadData, 32'hCAFE_F00D);
        bus.ReadSel = 1'b0;
        #1 check("rd_lo", bus.ReadData, 32'h0000_0005);
        @(negedge clk);

        // 4. Divide by zero.
        mt_write(1'b1, 1'b0, 32'h1111_1111);
        mt_write(1'b0, 1'b1, 32'h2222_2222);
`ifdef HILO_DIV0_HOLD_EN
        launch(3'd3, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'h1111_1111, 32'h2222_2222, DIV_N, 1'b0);
`else
        launch(3'd3, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, DIV_N, 1'b0);
`endif
        wait_commit(0);

        // 5. Asynchronous reset in the third busy cycle of a mult.
        mt_write(1'b1, 1'b1, 32'h7777_0000);
        launch(3'd2, 32'd1, 32'h0BAD_0BAD, 32'h0BAD_0BAD,
               32'h0BAD_0BAD, 32'h0BAD_0BAD, MULT_N, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", {31'd0, bus.Busy}, 32'd0);
        check("arst_hi", bus.HI, 32'd0);
        check("arst_lo", bus.LO, 32'd0);
        void'(sb.pop_front());
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_hi", bus.HI, 32'd0);
        launch(3'd1, 32'd1, 32'hA5A5_A5A5, 32'h5A5A_5A5A,
               32'hA5A5_A5A5, 32'h5A5A_5A5A, MULT_N, 1'b0);
        wait_commit(0);

        // 6. Invalid codes are no-ops; the mtlo that accompanies one still happens.
        bus.Start = 1'b1; bus.MDCCtrl = 3'd0;
        @(negedge clk);
        idle_inputs();
        check("inv0_busy", {31'd0, bus.Busy}, 32'd0);
        bus.Start = 1'b1; bus.MDCCtrl = 3'd7;
        bus.LOWrite = 1'b1; bus.SrcA = 32'h0000_0777;
        @(negedge clk);
        idle_inputs();
        m_lo = 32'h0000_0777;
        check("inv7_busy", {31'd0, bus.Busy}, 32'd0);
        check("inv7_lo", bus.LO, m_lo);
        // A valid Start together with mtlo: the write is dropped.
        launch(3'd2, 32'd1, 32'h0000_00AA, 32'h0000_00BB,
               32'h0000_00AA, 32'h0000_00BB, MULT_N, 1'b1);
        check("conflict_lo", bus.LO, 32'h0000_0777);
        wait_commit(0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
